// File: rtl/uart_reg_pkg.sv
// Shared types, constants and sizing helpers for the UART register command decoder.
package uart_reg_pkg;

    // Decoder states; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        RESP      = 2'd2
    } state_e;

    // Command byte layout: bit 7 selects write, bits [6:0] carry the address.
    localparam int CMD_WR_BIT = 7;
    localparam int CMD_ADDR_W = 7;

    // Inter-byte timeout in clock cycles (integer division of the bit period).
    function automatic int timeout_cycles(input int clk_hz, input int bit_rate,
                                          input int timeout_bits);
        return timeout_bits * (clk_hz / bit_rate);
    endfunction

    // Width of a counter able to hold values 0..cycles.
    function automatic int timer_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    // True when a command address maps onto an implemented register.
    function automatic logic addr_in_range(input logic [CMD_ADDR_W-1:0] addr,
                                           input int num_regs);
        return int'(addr) < num_regs;
    endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Clearable, enabled up-counter with a terminal-count flag.
module uart_cmd_timer #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [WIDTH-1:0] r_count;

    // Count enabled cycles since the last clear; clear takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Flags the final cycle of the budget so the caller can act on that edge.
    assign o_tc = (r_count == WIDTH'(TERMINAL));

endmodule

// File: rtl/uart_reg_cmd.sv
// Decodes received UART bytes into register-file writes (two bytes) and
// reads (one byte); read data is returned on a valid/ready byte interface.
module uart_reg_cmd
    import uart_reg_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 11520,
    parameter int NUM_REGS     = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx_valid,
    input  logic [7:0]            uart_rx_data,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic [NUM_REGS*8-1:0] reg_q,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic                  addr_err,
    output logic                  cmd_timeout,
    output logic                  rx_overrun
);

    localparam int TIMEOUT_CYCLES = timeout_cycles(CLK_HZ, BIT_RATE, TIMEOUT_BITS);
    localparam int TIMER_W        = timer_width(TIMEOUT_CYCLES);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [CMD_ADDR_W-1:0] r_addr;
    logic [7:0]            r_regs [NUM_REGS];
    logic                  r_tx_valid;
    logic [7:0]            r_tx_data;
    logic                  r_wr_strobe;
    logic [CMD_ADDR_W-1:0] r_wr_addr;
    logic                  r_addr_err;
    logic                  r_cmd_timeout;
    logic                  r_rx_overrun;

    logic                  w_cmd_wr;
    logic [CMD_ADDR_W-1:0] w_cmd_addr;
    logic [7:0]            w_rd_data;
    logic                  w_tc;
    logic                  w_latch_addr;
    logic                  w_timer_clr;
    logic                  w_load_tx;
    logic [7:0]            w_tx_byte;
    logic                  w_tx_done;
    logic                  w_wr_en;
    logic                  w_addr_err;
    logic                  w_timeout;
    logic                  w_overrun;

    assign w_cmd_wr   = uart_rx_data[CMD_WR_BIT];
    assign w_cmd_addr = uart_rx_data[CMD_ADDR_W-1:0];

    uart_cmd_timer #(
        .WIDTH    (TIMER_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_timer_clr),
        .i_en  (r_state == WAIT_DATA),
        .o_tc  (w_tc)
    );

    // Read mux: register addressed by the incoming command byte.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd_addr == CMD_ADDR_W'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch_addr = 1'b0;
        w_timer_clr  = 1'b0;
        w_load_tx    = 1'b0;
        w_tx_byte    = 8'h00;
        w_tx_done    = 1'b0;
        w_wr_en      = 1'b0;
        w_addr_err   = 1'b0;
        w_timeout    = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            IDLE: begin
                if (uart_rx_valid) begin
                    if (w_cmd_wr) begin
                        w_latch_addr = 1'b1;
                        w_timer_clr  = 1'b1;
                        w_state_nxt  = WAIT_DATA;
                    end else begin
                        w_load_tx   = 1'b1;
                        w_state_nxt = RESP;
                        if (addr_in_range(w_cmd_addr, NUM_REGS)) begin
                            w_tx_byte = w_rd_data;
                        end else begin
                            w_addr_err = 1'b1;
                        end
                    end
                end
            end
            WAIT_DATA: begin
                // A data byte in the final timer cycle wins over the timeout.
                if (uart_rx_valid) begin
                    if (addr_in_range(r_addr, NUM_REGS)) begin
                        w_wr_en = 1'b1;
                    end else begin
                        w_addr_err = 1'b1;
                    end
                    w_state_nxt = IDLE;
                end else if (w_tc) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            RESP: begin
                w_overrun = uart_rx_valid;
                if (r_tx_valid && tx_ready) begin
                    w_tx_done   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Register file and latched write address.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register file is flops driving board pins, so it is reset explicitly, unlike a RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_addr <= '0;
        end else begin
            if (w_latch_addr) begin
                r_addr <= w_cmd_addr;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_en && (r_addr == CMD_ADDR_W'(i))) begin
                    r_regs[i] <= uart_rx_data;
                end
            end
        end
    end

    // Read-response byte: loaded on a read command, released on handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else if (w_load_tx) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_tx_byte;
        end else if (w_tx_done) begin
            r_tx_valid <= 1'b0;
        end
    end

    // Registered one-cycle status pulses and last-write address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_strobe   <= 1'b0;
            r_wr_addr     <= '0;
            r_addr_err    <= 1'b0;
            r_cmd_timeout <= 1'b0;
            r_rx_overrun  <= 1'b0;
        end else begin
            r_wr_strobe   <= w_wr_en;
            r_addr_err    <= w_addr_err;
            r_cmd_timeout <= w_timeout;
            r_rx_overrun  <= w_overrun;
            if (w_wr_en) begin
                r_wr_addr <= r_addr;
            end
        end
    end

    // Flatten the register file onto the export bus, reg n at [8n+7:8n].
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*8 +: 8] = r_regs[i];
        end
    end

    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign wr_strobe   = r_wr_strobe;
    assign wr_addr     = r_wr_addr;
    assign addr_err    = r_addr_err;
    assign cmd_timeout = r_cmd_timeout;
    assign rx_overrun  = r_rx_overrun;

endmodule

// File: tb/tb_uart_reg_cmd.sv
// Directed, table-driven bench for uart_reg_cmd plus hand-written timeout sequences.
module tb_uart_reg_cmd;

    localparam int TB_CLK_HZ       = 1_000_000;
    localparam int TB_BIT_RATE     = 100_000;
    localparam int TB_NUM_REGS     = 16;
    localparam int TB_TIMEOUT_BITS = 4;
    // 4 bit periods of 10 clocks each.
    localparam int TC = 40;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     uart_rx_valid;
    logic [7:0]               uart_rx_data;
    logic                     tx_valid;
    logic [7:0]               tx_data;
    logic                     tx_ready;
    logic [TB_NUM_REGS*8-1:0] reg_q;
    logic                     wr_strobe;
    logic [6:0]               wr_addr;
    logic                     addr_err;
    logic                     cmd_timeout;
    logic                     rx_overrun;

    int checks   = 0;
    int failures = 0;

    uart_reg_cmd #(
        .CLK_HZ       (TB_CLK_HZ),
        .BIT_RATE     (TB_BIT_RATE),
        .NUM_REGS     (TB_NUM_REGS),
        .TIMEOUT_BITS (TB_TIMEOUT_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .reg_q         (reg_q),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr),
        .addr_err      (addr_err),
        .cmd_timeout   (cmd_timeout),
        .rx_overrun    (rx_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       rxv;
        logic [7:0] rxd;
        logic       rdy;
        logic       e_txv;
        logic [7:0] e_txd;
        logic       e_wrs;
        logic [6:0] e_wra;
        logic       e_aerr;
        logic       e_to;
        logic       e_ovr;
        int         ridx;
        logic [7:0] e_reg;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic tick(input logic r, input logic v, input logic [7:0] d, input logic rdy);
        reset         = r;
        uart_rx_valid = v;
        uart_rx_data  = d;
        tx_ready      = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input string n, input logic r, input logic v, input logic [7:0] d,
                       input logic rdy, input logic txv, input logic [7:0] txd,
                       input logic wrs, input logic [6:0] wra, input logic aerr,
                       input logic to, input logic ovr, input int ridx, input logic [7:0] ereg);
        vec_t x;
        x.name = n; x.rst = r; x.rxv = v; x.rxd = d; x.rdy = rdy;
        x.e_txv = txv; x.e_txd = txd; x.e_wrs = wrs; x.e_wra = wra;
        x.e_aerr = aerr; x.e_to = to; x.e_ovr = ovr; x.ridx = ridx; x.e_reg = ereg;
        vecs.push_back(x);
    endtask

    function automatic logic [7:0] reg_at(input int idx);
        return reg_q[idx*8 +: 8];
    endfunction

    initial begin
        reset         = 1'b1;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h00;
        tx_ready      = 1'b0;

        //   name            rst v  data  rdy txv txd   wrs wra   aerr to ovr reg  val
        add("reset",          1, 0, 8'h00, 0,  0, 8'h00, 0, 7'h00, 0, 0, 0,  5, 8'h00);
        add("wr5_cmd",        0, 1, 8'h85, 0,  0, 8'h00, 0, 7'h00, 0, 0, 0,  5, 8'h00);
        add("wr5_data",       0, 1, 8'h1F, 0,  0, 8'h00, 1, 7'h05, 0, 0, 0,  5, 8'h1F);
        add("wr5_after",      0, 0, 8'h00, 0,  0, 8'h00, 0, 7'h05, 0, 0, 0,  4, 8'h00);
        add("rd5_cmd",        0, 1, 8'h05, 1,  1, 8'h1F, 0, 7'h05, 0, 0, 0,  5, 8'h1F);
        add("rd5_hs",         0, 0, 8'h00, 1,  0, 8'h1F, 0, 7'h05, 0, 0, 0,  6, 8'h00);
        add("wrbad_cmd",      0, 1, 8'hAA, 0,  0, 8'h1F, 0, 7'h05, 0, 0, 0,  5, 8'h1F);
        add("wrbad_data",     0, 1, 8'h1F, 0,  0, 8'h1F, 0, 7'h05, 1, 0, 0,  5, 8'h1F);
        add("wrbad_after",    0, 0, 8'h00, 0,  0, 8'h1F, 0, 7'h05, 0, 0, 0, 10, 8'h00);
        add("rdbad_cmd",      0, 1, 8'h2A, 1,  1, 8'h00, 0, 7'h05, 1, 0, 0,  5, 8'h1F);
        add("rdbad_hs",       0, 0, 8'h00, 1,  0, 8'h00, 0, 7'h05, 0, 0, 0,  5, 8'h1F);
        add("wr2_cmd",        0, 1, 8'h82, 0,  0, 8'h00, 0, 7'h05, 0, 0, 0,  2, 8'h00);
        add("wr2_data",       0, 1, 8'h3C, 0,  0, 8'h00, 1, 7'h02, 0, 0, 0,  2, 8'h3C);
        add("rd2_cmd",        0, 1, 8'h02, 0,  1, 8'h3C, 0, 7'h02, 0, 0, 0,  2, 8'h3C);
        add("ovr_wr1",        0, 1, 8'h81, 0,  1, 8'h3C, 0, 7'h02, 0, 0, 1,  1, 8'h00);
        add("ovr_hold",       0, 0, 8'h00, 0,  1, 8'h3C, 0, 7'h02, 0, 0, 0,  1, 8'h00);
        add("ovr_hs_byte",    0, 1, 8'h3D, 1,  0, 8'h3C, 0, 7'h02, 0, 0, 1,  1, 8'h00);
        add("ovr_after",      0, 0, 8'h00, 0,  0, 8'h3C, 0, 7'h02, 0, 0, 0,  1, 8'h00);
        add("wr7_cmd",        0, 1, 8'h87, 0,  0, 8'h3C, 0, 7'h02, 0, 0, 0,  7, 8'h00);
        add("wr7_data",       0, 1, 8'hA5, 0,  0, 8'h3C, 1, 7'h07, 0, 0, 0,  7, 8'hA5);
        add("rd7_back2back",  0, 1, 8'h07, 1,  1, 8'hA5, 0, 7'h07, 0, 0, 0,  7, 8'hA5);
        add("rd7_hs",         0, 0, 8'h00, 1,  0, 8'hA5, 0, 7'h07, 0, 0, 0,  7, 8'hA5);
        add("wr15_cmd",       0, 1, 8'h8F, 0,  0, 8'hA5, 0, 7'h07, 0, 0, 0, 15, 8'h00);
        add("wr15_data",      0, 1, 8'h66, 0,  0, 8'hA5, 1, 7'h0F, 0, 0, 0, 15, 8'h66);
        add("rd15_cmd",       0, 1, 8'h0F, 1,  1, 8'h66, 0, 7'h0F, 0, 0, 0, 15, 8'h66);
        add("rd15_hs",        0, 0, 8'h00, 1,  0, 8'h66, 0, 7'h0F, 0, 0, 0, 15, 8'h66);
        add("rd16_cmd",       0, 1, 8'h10, 1,  1, 8'h00, 0, 7'h0F, 1, 0, 0, 15, 8'h66);
        add("rd16_hs",        0, 0, 8'h00, 1,  0, 8'h00, 0, 7'h0F, 0, 0, 0, 15, 8'h66);
        add("wr16_cmd",       0, 1, 8'h90, 0,  0, 8'h00, 0, 7'h0F, 0, 0, 0, 15, 8'h66);
        add("wr16_data",      0, 1, 8'h77, 0,  0, 8'h00, 0, 7'h0F, 1, 0, 0, 15, 8'h66);
        add("wr16_after",     0, 0, 8'h00, 0,  0, 8'h00, 0, 7'h0F, 0, 0, 0,  0, 8'h00);
        add("wr4_cmd",        0, 1, 8'h84, 0,  0, 8'h00, 0, 7'h0F, 0, 0, 0,  4, 8'h00);
        add("wr4_reset",      1, 0, 8'h00, 0,  0, 8'h00, 0, 7'h00, 0, 0, 0, 15, 8'h00);
        add("rd55_after_rst", 0, 1, 8'h55, 1,  1, 8'h00, 0, 7'h00, 1, 0, 0,  4, 8'h00);
        add("rd55_hs",        0, 0, 8'h00, 1,  0, 8'h00, 0, 7'h00, 0, 0, 0,  4, 8'h00);

        @(negedge clk);
        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].rxv, vecs[i].rxd, vecs[i].rdy);
            check({vecs[i].name, ".tx_valid"},    32'(tx_valid),           32'(vecs[i].e_txv));
            check({vecs[i].name, ".tx_data"},     32'(tx_data),            32'(vecs[i].e_txd));
            check({vecs[i].name, ".wr_strobe"},   32'(wr_strobe),          32'(vecs[i].e_wrs));
            check({vecs[i].name, ".wr_addr"},     32'(wr_addr),            32'(vecs[i].e_wra));
            check({vecs[i].name, ".addr_err"},    32'(addr_err),           32'(vecs[i].e_aerr));
            check({vecs[i].name, ".cmd_timeout"}, 32'(cmd_timeout),        32'(vecs[i].e_to));
            check({vecs[i].name, ".rx_overrun"},  32'(rx_overrun),         32'(vecs[i].e_ovr));
            check({vecs[i].name, ".reg"},         32'(reg_at(vecs[i].ridx)), 32'(vecs[i].e_reg));
        end

        // Write command with no data byte: timeout exactly TC cycles after the command edge.
        begin
            int  n    = 0;
            bit  seen = 1'b0;
            bit  wrs  = 1'b0;
            tick(0, 1, 8'h83, 0);
            check("to_cmd.cmd_timeout", 32'(cmd_timeout), 32'd0);
            for (int j = 1; j <= TC + 8 && !seen; j++) begin
                tick(0, 0, 8'h00, 0);
                if (wr_strobe) wrs = 1'b1;
                if (cmd_timeout) begin
                    seen = 1'b1;
                    n    = j;
                end
            end
            check("to_seen",    32'(seen), 32'd1);
            check("to_latency", n,         TC);
            check("to_no_wr",   32'(wrs),  32'd0);
            check("to_reg3",    32'(reg_at(3)), 32'h00);
            tick(0, 0, 8'h00, 0);
            check("to_pulse_width", 32'(cmd_timeout), 32'd0);
            tick(0, 1, 8'h1F, 1);
            check("to_rd1f.tx_valid", 32'(tx_valid), 32'd1);
            check("to_rd1f.tx_data",  32'(tx_data),  32'h00);
            check("to_rd1f.addr_err", 32'(addr_err), 32'd1);
            check("to_rd1f.wr_strobe", 32'(wr_strobe), 32'd0);
            tick(0, 0, 8'h00, 1);
            check("to_rd1f_hs.tx_valid", 32'(tx_valid), 32'd0);
        end

        // Data byte arriving in the final timer cycle wins over the timeout.
        begin
            bit early = 1'b0;
            tick(0, 1, 8'h83, 0);
            for (int j = 1; j <= TC - 1; j++) begin
                tick(0, 0, 8'h00, 0);
                if (cmd_timeout) early = 1'b1;
            end
            check("last.no_early_timeout", 32'(early), 32'd0);
            tick(0, 1, 8'h44, 0);
            check("last.wr_strobe",   32'(wr_strobe),   32'd1);
            check("last.wr_addr",     32'(wr_addr),     32'h03);
            check("last.cmd_timeout", 32'(cmd_timeout), 32'd0);
            check("last.reg3",        32'(reg_at(3)),   32'h44);
            tick(0, 0, 8'h00, 0);
            check("last_after.cmd_timeout", 32'(cmd_timeout), 32'd0);
            check("last_after.wr_strobe",   32'(wr_strobe),   32'd0);
            check("last_after.reg3",        32'(reg_at(3)),   32'h44);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
